// File: rtl/ehl_gpio_mbank_apb.sv
// Multi-bank GPIO controller behind an APB slave. Each bank has its own
// output, enable, input filter and interrupt register set.
module ehl_gpio_mbank_apb #(
    parameter int              WIDTH        = 32,
    parameter int              NBANKS       = 2,
    parameter int              FLT_W        = 8,
    parameter bit              IFG_POLARITY = 1'b1,
    parameter logic [WIDTH-1:0] DOUT_INIT   = '0,
    parameter logic [WIDTH-1:0] OE_INIT     = '0
) (
    input  logic                     pclk,
    input  logic                     presetn,
    input  logic [7:0]               paddr,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [WIDTH-1:0]         pwdata,
    output logic [WIDTH-1:0]         prdata,
    output logic                     pready,
    output logic                     pslverr,
    input  logic [NBANKS*WIDTH-1:0]  gpio_in,
    output logic [NBANKS*WIDTH-1:0]  gpio_out,
    output logic [NBANKS*WIDTH-1:0]  gpio_oe,
    output logic [NBANKS-1:0]        irq,
    output logic                     ifg
);

    localparam logic [3:0] R_DOUT   = 4'd0;
    localparam logic [3:0] R_DSET   = 4'd1;
    localparam logic [3:0] R_DCLR   = 4'd2;
    localparam logic [3:0] R_DTGL   = 4'd3;
    localparam logic [3:0] R_OE     = 4'd4;
    localparam logic [3:0] R_DIN    = 4'd5;
    localparam logic [3:0] R_IEN    = 4'd6;
    localparam logic [3:0] R_ITYPE  = 4'd7;
    localparam logic [3:0] R_IPOL   = 4'd8;
    localparam logic [3:0] R_IBOTH  = 4'd9;
    localparam logic [3:0] R_IFLAG  = 4'd10;
    localparam logic [3:0] R_FLTEN  = 4'd11;
    localparam logic [3:0] R_FLTDIV = 4'd12;

    logic             access;
    logic [1:0]       bank;
    logic [3:0]       idx;
    logic             bank_ok;
    logic             idx_ok;
    logic             err;
    logic             wr_en;
    logic [NBANKS-1:0] irq_raw;
    logic [WIDTH-1:0] rd_bank [NBANKS];
    logic             unused_paddr;

    assign access       = psel & penable;
    assign bank         = paddr[7:6];
    assign idx          = paddr[5:2];
    assign unused_paddr = ^paddr[1:0];
    assign bank_ok      = (int'(bank) < NBANKS);
    assign idx_ok       = (idx <= R_FLTDIV);
    assign err          = access & (~bank_ok | ~idx_ok | (pwrite & (idx == R_DIN)));
    assign wr_en        = access & pwrite & ~err;
    assign pslverr      = err;
    assign pready       = 1'b1;

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic             sel;
        logic [WIDTH-1:0] pin;
        logic [WIDTH-1:0] dout, oe, ien, itype, ipol, iboth, iflag, flten;
        logic [WIDTH-1:0] sync1, sync2, hist0, hist1, din, din_q, din_nxt;
        logic [WIDTH-1:0] tmask, all_hi, all_lo;
        logic [WIDTH-1:0] rise, fall, edge_evt, lvl_evt, evt, w1c, rd;
        logic [FLT_W-1:0] fltdiv, pscnt;
        logic             tick;
        logic             irq_q;

        assign sel = wr_en & (int'(bank) == b);
        assign pin = gpio_in[b*WIDTH +: WIDTH];

        always_ff @(posedge pclk or negedge presetn) begin
            if (!presetn) begin
                dout   <= DOUT_INIT;
                oe     <= OE_INIT;
                ien    <= '0;
                itype  <= '0;
                ipol   <= '0;
                iboth  <= '0;
                flten  <= '0;
                fltdiv <= '0;
            end else if (sel) begin
                case (idx)
                    R_DOUT:   dout   <= pwdata;
                    R_DSET:   dout   <= dout | pwdata;
                    R_DCLR:   dout   <= dout & ~pwdata;
                    R_DTGL:   dout   <= dout ^ pwdata;
                    R_OE:     oe     <= pwdata;
                    R_IEN:    ien    <= pwdata;
                    R_ITYPE:  itype  <= pwdata;
                    R_IPOL:   ipol   <= pwdata;
                    R_IBOTH:  iboth  <= pwdata;
                    R_FLTEN:  flten  <= pwdata;
                    R_FLTDIV: fltdiv <= pwdata[FLT_W-1:0];
                    default:  ;
                endcase
            end
        end

        // A write to FLTDIV restarts the prescaler so the new period starts cleanly.
        assign tick = (pscnt == fltdiv);

        always_ff @(posedge pclk or negedge presetn) begin
            if (!presetn) begin
                pscnt <= '0;
            end else if (sel && (idx == R_FLTDIV)) begin
                pscnt <= '0;
            end else if (tick) begin
                pscnt <= '0;
            end else begin
                pscnt <= pscnt + {{(FLT_W-1){1'b0}}, 1'b1};
            end
        end

        // The three filter samples are hist1, hist0 and the sample taken on this tick.
        assign tmask   = {WIDTH{tick}};
        assign all_hi  = tmask & hist1 & hist0 & sync2;
        assign all_lo  = tmask & ~(hist1 | hist0 | sync2);
        assign din_nxt = (flten & ((din | all_hi) & ~all_lo)) | (~flten & sync2);

        always_ff @(posedge pclk or negedge presetn) begin
            if (!presetn) begin
                sync1 <= '0;
                sync2 <= '0;
                hist0 <= '0;
                hist1 <= '0;
                din   <= '0;
                din_q <= '0;
            end else begin
                sync1 <= pin;
                sync2 <= sync1;
                din   <= din_nxt;
                din_q <= din;
                if (tick) begin
                    hist1 <= hist0;
                    hist0 <= sync2;
                end
            end
        end

        assign rise     = din & ~din_q;
        assign fall     = ~din & din_q;
        assign edge_evt = (iboth & (rise | fall)) | (~iboth & ~ipol & rise) | (~iboth & ipol & fall);
        assign lvl_evt  = ~(din ^ ipol);
        assign evt      = (itype & lvl_evt) | (~itype & edge_evt);
        assign w1c      = (sel && (idx == R_IFLAG)) ? pwdata : '0;

        // New events override a simultaneous W1C of the same bit.
        always_ff @(posedge pclk or negedge presetn) begin
            if (!presetn) begin
                iflag <= '0;
                irq_q <= 1'b0;
            end else begin
                iflag <= (iflag & ~w1c) | evt;
                irq_q <= |(iflag & ien);
            end
        end

        always_comb begin
            rd = '0;
            case (idx)
                R_DOUT:   rd = dout;
                R_OE:     rd = oe;
                R_DIN:    rd = din;
                R_IEN:    rd = ien;
                R_ITYPE:  rd = itype;
                R_IPOL:   rd = ipol;
                R_IBOTH:  rd = iboth;
                R_IFLAG:  rd = iflag;
                R_FLTEN:  rd = flten;
                R_FLTDIV: rd[FLT_W-1:0] = fltdiv;
                default:  rd = '0;
            endcase
        end

        assign gpio_out[b*WIDTH +: WIDTH] = dout;
        assign gpio_oe[b*WIDTH +: WIDTH]  = oe;
        assign irq_raw[b]                 = irq_q;
        assign rd_bank[b]                 = rd;
    end

    always_comb begin
        prdata = '0;
        if (access && !err) begin
            for (int b = 0; b < NBANKS; b++) begin
                if (int'(bank) == b) begin
                    prdata = rd_bank[b];
                end
            end
        end
    end

    assign irq = IFG_POLARITY ? irq_raw : ~irq_raw;
    assign ifg = IFG_POLARITY ? (|irq_raw) : ~(|irq_raw);

endmodule

// File: doc/ehl_gpio_mbank_apb.md
# ehl_gpio_mbank_apb

Multi-bank GPIO controller with a native AMBA APB slave, generalising the single-bank GPIO APB block. It provides NBANKS banks of WIDTH pins each, with:
- atomic set/clear/toggle output writes;
- per-bank programmable input glitch filter;
- per-pin edge/level interrupt modes with write-1-to-clear flags;
- per-bank and combined interrupt outputs.

It sits on the peripheral APB bus next to the other ehl_* peripherals and drives pad-level out/oe signals directly.

## Interface
Parameters:
- WIDTH, 32, pins per bank and APB data width (8..32)
- NBANKS, 2, number of banks (1..4)
- FLT_W, 8, width of per-bank filter prescaler register
- IFG_POLARITY, 1, active level of ifg and irq outputs (1 = high)
- DOUT_INIT, 0, reset value of every bank's DOUT
- OE_INIT, 0, reset value of every bank's OE

Ports:
- pclk  in  1  APB clock; the only clock in the block
- presetn  in  1  asynchronous active-low reset
- paddr  in  8  byte address; [5:2] register index, [7:6] bank, [1:0] ignored
- psel, penable, pwrite  in  1  APB controls
- pwdata  in  WIDTH  write data
- prdata  out  WIDTH  read data
- pready  out  1  tied 1; zero wait states
- pslverr  out  1  error response
- gpio_in  in  NBANKS*WIDTH  asynchronous pad inputs; bank b uses bits [b*WIDTH +: WIDTH]
- gpio_out, gpio_oe  out  NBANKS*WIDTH  pad data and output enable
- irq  out  NBANKS  per-bank interrupt
- ifg  out  1  OR of all banks' interrupts

## Operation
Per-bank registers, selected by index:
- 0 DOUT: rw; drives gpio_out.
- 1 DSET, 2 DCLR, 3 DTGL: wo; DOUT |= wd, &= ~wd, ^= wd respectively; read as 0.
- 4 OE: rw; drives gpio_oe.
- 5 DIN: ro; filtered, synchronised input.
- 6 IEN: rw; interrupt enable.
- 7 ITYPE: rw; 0 = edge, 1 = level.
- 8 IPOL: rw; edge: 0 rising, 1 falling; level: 0 low, 1 high.
- 9 IBOTH: rw; for edge pins, 1 = both edges (IPOL ignored).
- 10 IFLAG: r/W1C.
- 11 FLTEN: rw; per-pin filter enable.
- 12 FLTDIV: rw, FLT_W bits; sample tick every FLTDIV+1 cycles.

Access and error rules:
- Access phase is psel & penable. Write commits on the pclk edge ending the access phase. Read data is combinational during the access phase; prdata is 0 otherwise.
- pslverr = 1 in the access phase for any of:
  - bank ≥ NBANKS;
  - register index 13..15;
  - a write to DIN.
- An errored access has no side effects.

Input path:
- Every pin passes through a 2-FF synchroniser.
- Filter disabled: DIN follows the synchroniser output, registered, so it updates 1 cycle later.
- Filter enabled:
  - A per-bank prescaler generates a tick.
  - On each tick the pin's 3-sample shift register shifts.
  - DIN changes only when all 3 samples equal the new value.

Interrupts:
- Edge detection compares DIN with its previous value (din_q).
- Level condition is DIN == IPOL, evaluated every cycle.
- IFLAG bit is set by an event regardless of IEN; IEN only masks irq.
- irq[b] = |(IFLAG & IEN) of bank b, registered, polarity per IFG_POLARITY. ifg = |irq (before polarity), same polarity.

Boundary cases:
- Event and W1C on the same bit in the same cycle: set wins, flag stays 1.
- Level pin with condition still true: W1C has no visible effect; flag stays 1.
- Changing ITYPE/IPOL does not clear flags.
- Writing FLTDIV restarts that bank's prescaler at 0.
- FLTDIV = 0: a tick every cycle.
- Prescaler wraps from FLTDIV to 0.
- Bits of pwdata above WIDTH do not exist; FLTDIV uses pwdata[FLT_W-1:0], and prdata upper bits read 0.

## Timing
Reset (presetn low, async):
- DOUT = DOUT_INIT and OE = OE_INIT on all banks.
- All other registers, synchronisers, filter state, din_q, IFLAG and prescalers = 0.
- irq and ifg inactive (= ~IFG_POLARITY); prdata 0; pslverr 0; pready 1.
- Reset asserted mid-transfer aborts the write; no partial update.

Latencies:
- APB write to gpio_out/gpio_oe: visible the cycle after the write edge.
- gpio_in to DIN, filter off: 3 pclk edges.
- gpio_in to IFLAG, filter off: 4 edges. IFLAG to irq/ifg: +1 edge.
- Filter on: DIN changes on the 3rd consecutive tick sampling the new value after synchronisation.

## Test plan
- Reset, then read all registers of bank 0 and bank 1 → DOUT = DOUT_INIT, OE = OE_INIT, rest 0; irq and ifg inactive.
- Bank 1: write DOUT = 0x0000_00F0, DSET 0x0F, DCLR 0x30, DTGL 0x101 → gpio_out[63:32] = 0x0000_01CE, and DSET reads 0.
- Bank 0 pin 3: IEN = 0x8, ITYPE = 0, IBOTH = 1, toggle gpio_in[3] 0→1→0 → IFLAG set 4 cycles after each edge, irq[0] one cycle later. W1C 0x8 in the same cycle as the second edge's event → flag remains 1.
- Bank 0 pin 0: FLTEN = 1, FLTDIV = 3, 1-cycle glitches on gpio_in[0] → DIN stays 0. A steady high → DIN = 1 within 2 + 3×4 cycles.
- Level-low interrupt on pin 5 held low: W1C → IFLAG still 1. Release high, then W1C → IFLAG = 0 and ifg deasserts.
- Access paddr 0x80 (bank 2, NBANKS = 2), index 13, or a write to DIN → pslverr = 1 and no register changes.
